// File: rtl/affine_alu_sequencer.sv
// Sequencer that time-shares one combinational ALU to evaluate a fixed 2-D affine transform.
// Optional build macro AFFINE_SAT_EN: saturate every RADD step on signed overflow instead of wrapping.

`ifndef DATA_BUS_SIZE
`define DATA_BUS_SIZE 8
`endif
`ifndef ALU_CODE_SIZE
`define ALU_CODE_SIZE 3
`endif
`ifndef RA
`define RA    3'b000
`endif
`ifndef RB
`define RB    3'b001
`endif
`ifndef RADD
`define RADD  3'b010
`endif
`ifndef RSUB
`define RSUB  3'b011
`endif
`ifndef RMULT
`define RMULT 3'b100
`endif

module affine_alu_sequencer #(
  parameter int                  n             = `DATA_BUS_SIZE,
  parameter int                  alu_code_size = `ALU_CODE_SIZE,
  parameter logic [n-1:0]        A11           = 8'h60,
  parameter logic [n-1:0]        A12           = 8'h40,
  parameter logic [n-1:0]        A21           = 8'hC0,
  parameter logic [n-1:0]        A22           = 8'h60,
  parameter int                  B1            = 5,
  parameter int                  B2            = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [n-1:0]             x_in,
  input  logic [n-1:0]             y_in,
  output logic                     ready,
  output logic                     done,
  output logic [n-1:0]             x_out,
  output logic [n-1:0]             y_out,
  output logic [n-1:0]             alu_a,
  output logic [n-1:0]             alu_b,
  output logic [alu_code_size-1:0] alu_func,
  input  logic [n-1:0]             alu_result,
  output logic [3:0]               o_state_dbg
);

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    MX1  = 4'd1,
    MX2  = 4'd2,
    AX   = 4'd3,
    BX   = 4'd4,
    MY1  = 4'd5,
    MY2  = 4'd6,
    AY   = 4'd7,
    BY   = 4'd8
  } state_t;

  localparam logic [n-1:0] W_B1 = B1[n-1:0];
  localparam logic [n-1:0] W_B2 = B2[n-1:0];

  state_t         r_state;
  state_t         w_next;
  logic [n-1:0]   r_x;
  logic [n-1:0]   r_y;
  logic [n-1:0]   r_acc;
  logic [n-1:0]   r_prod;
  logic [n-1:0]   r_xreg;
  logic [n-1:0]   r_x_out;
  logic [n-1:0]   r_y_out;
  logic           r_done;
  logic [n-1:0]   w_wb;

  // Handshake: start is honoured only on an edge where ready is high; done is a
  // one-cycle pulse coinciding with the atomic update of x_out/y_out.
  assign ready       = (r_state == IDLE);
  assign done        = r_done;
  assign x_out       = r_x_out;
  assign y_out       = r_y_out;
  assign o_state_dbg = r_state;

  // ALU drive is a pure function of state and the latched operands.
  always_comb begin
    w_next   = r_state;
    alu_a    = '0;
    alu_b    = '0;
    alu_func = `RB;
    case (r_state)
      IDLE: begin
        if (start) w_next = MX1;
      end
      MX1: begin
        alu_a    = A11;
        alu_b    = r_x;
        alu_func = `RMULT;
        w_next   = MX2;
      end
      MX2: begin
        alu_a    = A12;
        alu_b    = r_y;
        alu_func = `RMULT;
        w_next   = AX;
      end
      AX: begin
        alu_a    = r_acc;
        alu_b    = r_prod;
        alu_func = `RADD;
        w_next   = BX;
      end
      BX: begin
        alu_a    = r_acc;
        alu_b    = W_B1;
        alu_func = `RADD;
        w_next   = MY1;
      end
      MY1: begin
        alu_a    = A21;
        alu_b    = r_x;
        alu_func = `RMULT;
        w_next   = MY2;
      end
      MY2: begin
        alu_a    = A22;
        alu_b    = r_y;
        alu_func = `RMULT;
        w_next   = AY;
      end
      AY: begin
        alu_a    = r_acc;
        alu_b    = r_prod;
        alu_func = `RADD;
        w_next   = BY;
      end
      BY: begin
        alu_a    = r_acc;
        alu_b    = W_B2;
        alu_func = `RADD;
        w_next   = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

`ifdef AFFINE_SAT_EN
  logic w_ovf;
  // Signed overflow: equal operand signs with a result of the other sign.
  always_comb begin
    w_ovf = (alu_func == `RADD) && (alu_a[n-1] == alu_b[n-1]) &&
            (alu_result[n-1] != alu_a[n-1]);
    w_wb  = alu_result;
    if (w_ovf) w_wb = alu_a[n-1] ? {1'b1, {(n-1){1'b0}}} : {1'b0, {(n-1){1'b1}}};
  end
`else
  assign w_wb = alu_result;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_acc   <= '0;
      r_prod  <= '0;
      r_xreg  <= '0;
      r_x_out <= '0;
      r_y_out <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_x <= x_in;
            r_y <= y_in;
          end
        end
        MX1, AX, MY1, AY: r_acc  <= w_wb;
        MX2, MY2:         r_prod <= w_wb;
        BX:               r_xreg <= w_wb;
        BY: begin
          r_x_out <= r_xreg;
          r_y_out <= w_wb;
          r_done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_affine_alu_sequencer.sv
// Directed-plus-random bench for affine_alu_sequencer with a behavioural ALU and transform model.
// Honours AFFINE_SAT_EN so the reference matches whichever build is compiled.

`ifndef DATA_BUS_SIZE
`define DATA_BUS_SIZE 8
`endif
`ifndef ALU_CODE_SIZE
`define ALU_CODE_SIZE 3
`endif
`ifndef RA
`define RA    3'b000
`endif
`ifndef RB
`define RB    3'b001
`endif
`ifndef RADD
`define RADD  3'b010
`endif
`ifndef RSUB
`define RSUB  3'b011
`endif
`ifndef RMULT
`define RMULT 3'b100
`endif

module tb_affine_alu_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] x_in;
  logic [7:0] y_in;
  logic       ready;
  logic       done;
  logic [7:0] x_out;
  logic [7:0] y_out;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_func;
  logic [7:0] alu_result;
  logic [3:0] state_dbg;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  affine_alu_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .x_in        (x_in),
    .y_in        (y_in),
    .ready       (ready),
    .done        (done),
    .x_out       (x_out),
    .y_out       (y_out),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_func    (alu_func),
    .alu_result  (alu_result),
    .o_state_dbg (state_dbg)
  );

  // Combinational ALU the sequencer is wired to.
  logic signed [15:0] alu_prod;
  always_comb begin
    alu_prod   = $signed(alu_a) * $signed(alu_b);
    alu_result = 8'h00;
    case (alu_func)
      `RA:     alu_result = alu_a;
      `RB:     alu_result = alu_b;
      `RADD:   alu_result = alu_a + alu_b;
      `RSUB:   alu_result = alu_a - alu_b;
      `RMULT:  alu_result = 8'(alu_prod >>> 7);
      default: alu_result = 8'h00;
    endcase
  end

  // Reference arithmetic on plain integers.
  function automatic int wrap8(input int v);
    logic signed [7:0] t;
    t = v[7:0];
    return int'(t);
  endfunction

  function automatic int q_mul(input int coef, input int v);
    return wrap8((coef * v) >>> 7);
  endfunction

  function automatic int q_add(input int a, input int b);
    int s;
    s = a + b;
`ifdef AFFINE_SAT_EN
    if (s > 127)  return 127;
    if (s < -128) return -128;
`endif
    return wrap8(s);
  endfunction

  function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y);
    int xi, yi, x2, y2;
    xi = int'($signed(x));
    yi = int'($signed(y));
    x2 = q_add(q_add(q_mul(96, xi), q_mul(64, yi)), 5);
    y2 = q_add(q_add(q_mul(-64, xi), q_mul(96, yi)), 12);
    return {x2[7:0], y2[7:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for done with a cycle budget; optionally toggles start/x/y while busy.
  task automatic wait_done(input bit noise, output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        x_in  = 8'($urandom);
        y_in  = 8'($urandom);
      end
      tick();
      cyc++;
    end
    start = 1'b0;
  endtask

  task automatic run(input string tag, input logic [7:0] x, input logic [7:0] y, input bit noise);
    int cyc;
    logic [15:0] exp;
    exp   = model(x, y);
    start = 1'b1;
    x_in  = x;
    y_in  = y;
    tick();
    start = 1'b0;
    x_in  = 8'($urandom);
    y_in  = 8'($urandom);
    check({tag, "_busy"}, 32'(ready), 32'd0);
    wait_done(noise, cyc);
    check({tag, "_latency"}, 32'(cyc), 32'd8);
    check({tag, "_x"}, 32'(x_out), 32'(exp[15:8]));
    check({tag, "_y"}, 32'(y_out), 32'(exp[7:0]));
    tick();
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_x_hold"}, 32'(x_out), 32'(exp[15:8]));
  endtask

  logic [2:0] func_seq [8];
  int cyc;

  initial begin
    func_seq = '{`RMULT, `RMULT, `RADD, `RADD, `RMULT, `RMULT, `RADD, `RADD};
    reset = 1'b1;
    start = 1'b0;
    x_in  = 8'h00;
    y_in  = 8'h00;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_x", 32'(x_out), 32'd0);
    check("rst_y", 32'(y_out), 32'd0);
    check("rst_func", 32'(alu_func), 32'(`RB));
    check("rst_ab", 32'({alu_a, alu_b}), 32'd0);

    // First transform with explicit ALU function sequence.
    start = 1'b1;
    x_in  = 8'd8;
    y_in  = 8'd16;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("seq_func%0d", i), 32'(alu_func), 32'(func_seq[i]));
      check($sformatf("seq_ready%0d", i), 32'(ready), 32'd0);
      tick();
    end
    check("seq_done", 32'(done), 32'd1);
    check("seq_x", 32'(x_out), 32'd19);
    check("seq_y", 32'(y_out), 32'd20);
    tick();
    check("seq_done_low", 32'(done), 32'd0);
    check("seq_ready_back", 32'(ready), 32'd1);

    run("neg8", 8'hF8, 8'h00, 1'b0);
    check("neg8_x_lit", 32'(x_out), 32'hFF);
    check("neg8_y_lit", 32'(y_out), 32'd16);
    run("max", 8'd127, 8'd127, 1'b0);
`ifdef AFFINE_SAT_EN
    check("max_x_lit", 32'(x_out), 32'h7F);
`else
    check("max_x_lit", 32'(x_out), 32'hA3);
`endif
    check("max_y_lit", 32'(y_out), 32'd43);

    // Abort at AY with start noise while busy.
    start = 1'b1;
    x_in  = 8'd8;
    y_in  = 8'd16;
    tick();
    for (int i = 0; i < 6; i++) begin
      start = 1'($urandom_range(0, 1));
      x_in  = 8'($urandom);
      tick();
    end
    start = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_done", 32'(done), 32'd0);
    check("abort_x", 32'(x_out), 32'd0);
    check("abort_y", 32'(y_out), 32'd0);
    check("abort_ready", 32'(ready), 32'd1);
    tick();
    check("abort_no_done", 32'(done), 32'd0);
    run("after_abort", 8'd8, 8'd16, 1'b1);

    // Back-to-back with start held high.
    start = 1'b1;
    x_in  = 8'd8;
    y_in  = 8'd16;
    tick();
    x_in  = 8'hF8;
    y_in  = 8'h00;
    start = 1'b1;
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    check("b2b_lat1", 32'(cyc), 32'd8);
    check("b2b_x1", 32'(x_out), 32'd19);
    check("b2b_y1", 32'(y_out), 32'd20);
    tick();
    start = 1'b0;
    wait_done(1'b0, cyc);
    check("b2b_period", 32'(cyc + 1), 32'd9);
    check("b2b_x2", 32'(x_out), 32'hFF);
    check("b2b_y2", 32'(y_out), 32'd16);
    tick();
    check("b2b_idle", 32'(ready), 32'd1);

    for (int k = 0; k < 16; k++) begin
      run($sformatf("rnd%0d", k), 8'($urandom), 8'($urandom), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
